// File: rtl/sdpram_read_arbiter.sv
// Round-robin arbiter sharing one SDPRAM read port between scanout (0) and rasterizer (1).
// Bursts are issued one word per cycle; responses are tagged to their owner one cycle later.
module sdpram_read_arbiter #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 16,
   parameter  int LEN_W  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic              req0Valid,
   input  logic [ADDR_W-1:0] req0Addr,
   input  logic [LEN_W-1:0]  req0Len,
   output logic              req0Ready,
   input  logic              req1Valid,
   input  logic [ADDR_W-1:0] req1Addr,
   input  logic [LEN_W-1:0]  req1Len,
   output logic              req1Ready,
   output logic              rdEn,
   output logic [ADDR_W-1:0] rdAddr,
   input  logic [DATA_W-1:0] rdData,
   output logic              rsp0Valid,
   output logic              rsp1Valid,
   output logic              rspLast,
   output logic [DATA_W-1:0] rspData,
   output logic              busy
);

   typedef enum logic {IDLE, BURST} state_e;

   state_e             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic               owner_q, owner_d;
   logic [ADDR_W-1:0]  next_addr_q, next_addr_d;
   logic [LEN_W-1:0]   beats_q, beats_d;
   logic               rsp0_q, rsp0_d;
   logic               rsp1_q, rsp1_d;
   logic               last_q, last_d;

   logic               gnt0, gnt1;
   logic               rd_en;
   logic [ADDR_W-1:0]  rd_addr;
   logic               issue_owner;
   logic               issue_last;
   logic               sel;
   logic [ADDR_W-1:0]  sel_addr;
   logic [LEN_W-1:0]   sel_len;

   // Explicit compare so the wrap is correct for non-power-of-two depths.
   function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
      if (a == ADDR_W'(DEPTH - 1)) return '0;
      return a + ADDR_W'(1);
   endfunction

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      next_addr_d  = next_addr_q;
      beats_d      = beats_q;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      rd_en        = 1'b0;
      rd_addr      = next_addr_q;
      issue_owner  = owner_q;
      issue_last   = 1'b0;
      // A lone request wins; on a tie the requester that did not win last time wins.
      sel          = !(req0Valid && (!req1Valid || last_grant_q));
      sel_addr     = sel ? req1Addr : req0Addr;
      sel_len      = sel ? req1Len  : req0Len;

      case (state_q)
         IDLE: begin
            if (req0Valid || req1Valid) begin
               gnt0         = !sel;
               gnt1         = sel;
               rd_en        = 1'b1;
               rd_addr      = sel_addr;
               issue_owner  = sel;
               issue_last   = (sel_len == '0);
               owner_d      = sel;
               last_grant_d = sel;
               next_addr_d  = wrap_inc(sel_addr);
               beats_d      = sel_len;
               state_d      = (sel_len == '0) ? IDLE : BURST;
            end
         end
         BURST: begin
            rd_en       = 1'b1;
            rd_addr     = next_addr_q;
            next_addr_d = wrap_inc(next_addr_q);
            beats_d     = beats_q - LEN_W'(1);
            issue_last  = (beats_q == LEN_W'(1));
            state_d     = issue_last ? IDLE : BURST;
         end
         default: state_d = IDLE;
      endcase

      rsp0_d = rd_en && !issue_owner;
      rsp1_d = rd_en && issue_owner;
      last_d = rd_en && issue_last;
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         rsp0_q       <= 1'b0;
         rsp1_q       <= 1'b0;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rsp0_q       <= rsp0_d;
         rsp1_q       <= rsp1_d;
         last_q       <= last_d;
      end
   end

   // Burst bookkeeping is always reloaded by a grant before BURST uses it.
   always_ff @(posedge clock) begin
      owner_q     <= owner_d;
      next_addr_q <= next_addr_d;
      beats_q     <= beats_d;
   end

   assign req0Ready = gnt0 && resetN;
   assign req1Ready = gnt1 && resetN;
   assign rdEn      = rd_en && resetN;
   assign rdAddr    = rd_addr;
   assign rsp0Valid = rsp0_q;
   assign rsp1Valid = rsp1_q;
   assign rspLast   = last_q;
   assign rspData   = rdData;
   assign busy      = (state_q == BURST);

endmodule
